bram_host_sequencer: RTL and testbench
======================================

# bram_host_sequencer

Host-side controller for the pipelined processor's single shared BRAM port and its core reset. It accepts load/readback/run commands over a valid/ready interface and drives `bram_din`, `shared_bram_addr` and `bram_wr_en` for instruction or data memory. It returns read data over a response channel. It holds the core in reset while memories are accessed, then releases it for a bounded or unbounded run.

## Interface
Parameters:
- `WIDTH`, 32, bits per word
- `SIZE`, 64, words per memory
- `NUM_COL`, 4, byte-enable columns
- `LOGSIZE`, $clog2(SIZE), localparam
- `ADDR_W`, LOGSIZE+3, localparam; byte address, MSB=1 selects data memory, MSB=0 selects instruction memory

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when high with cmd_valid
- `cmd_op`  in  2  00 WRITE, 01 READ, 10 RUN, 11 HALT
- `cmd_addr`  in  ADDR_W  byte address (WRITE/READ)
- `cmd_data`  in  WIDTH  write data
- `cmd_be`  in  NUM_COL  write byte enables
- `cmd_cycles`  in  32  RUN length; 0 = unbounded
- `rsp_valid`  out  1  read data valid
- `rsp_ready`  in  1  host accepts response
- `rsp_data`  out  WIDTH  read data
- `bram_din`  out  WIDTH  to processor
- `shared_bram_addr`  out  ADDR_W  to processor
- `bram_wr_en`  out  NUM_COL  to processor
- `bram_dout`  in  WIDTH  from processor
- `core_reset`  out  1  active-high reset to processor
- `busy`  out  1  state != IDLE
- `run_done`  out  1  one-cycle pulse at end of run
- `cycle_count`  out  32  cycles core spent out of reset in the last/current run

## Operation
- States: IDLE, WR, RD_ADDR, RD_WAIT, RD_RESP, RUN.
- `cmd_ready` = (IDLE) or (RUN and cmd_op==HALT). It is combinational on state and cmd_op.
- IDLE + WRITE accepted → WR for one cycle. Drive addr/din and `bram_wr_en=cmd_be`, then return to IDLE. No response.
- IDLE + READ accepted → RD_ADDR (drive addr) → RD_WAIT (hold addr, capture `bram_dout` into rsp_data at end of cycle) → RD_RESP (`rsp_valid`=1, held with data stable until rsp_ready) → IDLE.
- IDLE + RUN accepted: clear cycle_count, enter RUN, `core_reset`=0.
- RUN: cycle_count increments every RUN cycle. If cmd_cycles≠0 (latched at accept), leave RUN after exactly N cycles.
- RUN + HALT accepted: leave RUN immediately. The HALT cycle counts as the final RUN cycle.
- Leaving RUN: `core_reset`=1 and `run_done`=1 for one cycle, next state IDLE.
- HALT accepted in IDLE: consumed, no effect, no pulse.
- `bram_wr_en`=0 in every state except WR. shared_bram_addr and bram_din hold their last value outside WR/RD_ADDR/RD_WAIT.
- cycle_count saturates at 2^32-1 and holds its value after the run until the next RUN accept.

## Timing
- Reset asserted (async) gives: state IDLE, core_reset=1, rsp_valid=0, rsp_data=0, shared_bram_addr=0, bram_din=0, bram_wr_en=0, run_done=0, cycle_count=0, busy=0.
- Reset mid-operation aborts it. Any partial write drops wr_en at once; a pending response is lost.
- Write: accept at edge T. wr_en high during cycle T+1. Next command acceptable at T+2 (2-cycle throughput).
- Read: accept at T. Address presented in T+1 and T+2. rsp_valid high from T+3. Minimum 4 cycles per read; the processor's 1-cycle BRAM and bram_sel register are covered by RD_WAIT.
- Backpressure: rsp_valid must not drop and rsp_data must not change until the rsp_valid&rsp_ready edge. IDLE follows that edge.
- RUN with N: core_reset low for exactly N cycles. run_done is high in the cycle after the last RUN cycle, coincident with core_reset returning high. cycle_count=N then.
- HALT while N cycles also expire in the same cycle: a single exit and a single run_done pulse.

## Test plan
- Reset: hold reset=0 mid-clock → all outputs at reset values immediately. core_reset=1, cmd_ready=1 after release.
- Write/read instr mem: WRITE addr=0x004, data=0x00500093, be=4'hF → one-cycle wr_en=4'hF with addr=0x004. READ 0x004 → rsp_data=0x00500093, rsp_valid at accept+3.
- Byte-enable data mem: WRITE addr=(1<<ADDR_W-1)|0x8, 0xFFFFFFFF be=F, then 0x000000AB be=0001. READ → 0xFFFFFFAB.
- Response backpressure: rsp_ready=0 for 5 cycles → rsp_valid/data stable, cmd_ready=0. cmd_ready=1 the cycle after the handshake.
- Bounded run: RUN cmd_cycles=10 → core_reset low 10 cycles, run_done single pulse, cycle_count=10. Program result readable afterward via READ.
- Unbounded run + HALT: RUN cmd_cycles=0, HALT after 25 cycles → exit, run_done pulse, cycle_count=25. WRITE/READ during RUN are not accepted (cmd_ready=0).

Source files
------------

// File: rtl/bram_host_sequencer.sv
// Host-side sequencer for the processor's shared BRAM port and core reset.
// Loads/reads instruction or data memory, then runs the core for N cycles.
`timescale 1ns/1ps
module bram_host_sequencer #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 64,
    parameter int NUM_COL  = 4,
    localparam int LOGSIZE = $clog2(SIZE),
    localparam int ADDR_W  = LOGSIZE + 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic [NUM_COL-1:0] cmd_be,
    input  logic [31:0]        cmd_cycles,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [WIDTH-1:0]   bram_din,
    output logic [ADDR_W-1:0]  shared_bram_addr,
    output logic [NUM_COL-1:0] bram_wr_en,
    input  logic [WIDTH-1:0]   bram_dout,
    output logic               core_reset,
    output logic               busy,
    output logic               run_done,
    output logic [31:0]        cycle_count
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_WAIT,
        RD_RESP,
        RUN
    } state_t;

    state_t      state;
    logic [31:0] run_len;
    logic        op_wr;
    logic        op_rd;
    logic        op_run;
    logic        halt_hs;
    logic        cnt_last;
    logic [31:0] cnt_inc;

    assign op_wr  = (cmd_op == OP_WRITE);
    assign op_rd  = (cmd_op == OP_READ);
    assign op_run = (cmd_op == OP_RUN);

    assign cmd_ready = (state == IDLE) ||
                       ((state == RUN) && (cmd_op == OP_HALT));
    assign busy      = (state != IDLE);

    assign halt_hs  = (state == RUN) && cmd_valid && (cmd_op == OP_HALT);
    // run_len of zero means the run only ends on HALT
    assign cnt_last = (run_len != 32'd0) &&
                      (cycle_count == run_len - 32'd1);
    assign cnt_inc  = (cycle_count == 32'hFFFF_FFFF) ?
                      cycle_count : cycle_count + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            run_len          <= '0;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            bram_din         <= '0;
            shared_bram_addr <= '0;
            bram_wr_en       <= '0;
            core_reset       <= 1'b1;
            run_done         <= 1'b0;
            cycle_count      <= '0;
        end else begin
            bram_wr_en <= '0;
            run_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        unique case (1'b1)
                            op_wr: begin
                                state            <= WR;
                                shared_bram_addr <= cmd_addr;
                                bram_din         <= cmd_data;
                                bram_wr_en       <= cmd_be;
                            end
                            op_rd: begin
                                state            <= RD_ADDR;
                                shared_bram_addr <= cmd_addr;
                            end
                            op_run: begin
                                state       <= RUN;
                                run_len     <= cmd_cycles;
                                cycle_count <= '0;
                                core_reset  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                WR: begin
                    state <= IDLE;
                end
                RD_ADDR: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp_data  <= bram_dout;
                    rsp_valid <= 1'b1;
                    state     <= RD_RESP;
                end
                RD_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RUN: begin
                    cycle_count <= cnt_inc;
                    // HALT and expiry in the same cycle share one exit
                    if (halt_hs || cnt_last) begin
                        state      <= IDLE;
                        core_reset <= 1'b1;
                        run_done   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_host_sequencer.sv
// Randomized bench for bram_host_sequencer against a
// transaction-schedule model of the host protocol.
`timescale 1ns/1ps
module tb_bram_host_sequencer;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 64;
    localparam int NUM_COL = 4;
    localparam int LOGSIZE = $clog2(SIZE);
    localparam int ADDR_W  = LOGSIZE + 3;
    localparam logic [1:0] OP_W    = 2'b00;
    localparam logic [1:0] OP_R    = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;
    localparam logic [ADDR_W-1:0] DBASE = {1'b1, {(ADDR_W-1){1'b0}}};
    localparam longint BIG = 64'sd1 << 40;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [WIDTH-1:0] cmd_data;
    logic [NUM_COL-1:0] cmd_be;
    logic [31:0] cmd_cycles;
    logic rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_data, bram_din, bram_dout;
    logic [ADDR_W-1:0] shared_bram_addr;
    logic [NUM_COL-1:0] bram_wr_en;
    logic core_reset, busy, run_done;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    bram_host_sequencer #(
        .WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NUM_COL)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_be(cmd_be),
        .cmd_cycles(cmd_cycles),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .bram_din(bram_din),
        .shared_bram_addr(shared_bram_addr),
        .bram_wr_en(bram_wr_en), .bram_dout(bram_dout),
        .core_reset(core_reset), .busy(busy),
        .run_done(run_done), .cycle_count(cycle_count)
    );

    // Processor side: 1-cycle BRAM, plus a stand-in core bumping dmem[1]
    logic [31:0] imem [SIZE] = '{default: '0};
    logic [31:0] dmem [SIZE] = '{default: '0};
    logic [31:0] dout_q = '0;
    logic [LOGSIZE-1:0] env_w;
    logic env_d;
    assign env_w = shared_bram_addr[LOGSIZE+1:2];
    assign env_d = shared_bram_addr[ADDR_W-1];
    assign bram_dout = dout_q;

    always @(posedge clk) begin
        for (int b = 0; b < NUM_COL; b++) begin
            if (bram_wr_en[b]) begin
                if (env_d) dmem[env_w][8*b +: 8] <= bram_din[8*b +: 8];
                else imem[env_w][8*b +: 8] <= bram_din[8*b +: 8];
            end
        end
        if (core_reset == 1'b0) dmem[1] <= dmem[1] + 32'd1;
        dout_q <= env_d ? dmem[env_w] : imem[env_w];
    end

    int checks = 0;
    int failures = 0;
    int rr_mode = 2;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: each accepted command is a transaction with a start
    // cycle; outputs follow from the cycle offset into it.
    longint cyc = 0, ta = 0, tl = 0, r_end = 0;
    int kind = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [31:0] m_din = '0, m_rsp = '0, m_rsp_new = '0, m_cnt = '0;
    logic [NUM_COL-1:0] m_be = '0;
    logic [31:0] rimem [SIZE] = '{default: '0};
    logic [31:0] rdmem [SIZE] = '{default: '0};
    logic act, done, e_valid, e_core, e_ready;
    logic [NUM_COL-1:0] e_wr;
    logic [LOGSIZE-1:0] mw;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            kind = 0; m_addr = '0; m_din = '0;
            m_rsp = '0; m_cnt = '0;
        end
        act = 1'b0; done = 1'b0;
        case (kind)
            1: act = (cyc == ta);
            2: act = (cyc < r_end);
            3: begin
                act  = (cyc < ta + tl);
                done = (cyc == ta + tl);
            end
            default: ;
        endcase
        if (kind == 3) m_cnt = (cyc - ta < tl) ? 32'(cyc - ta) : 32'(tl);
        if (kind == 2 && cyc == ta + 2) m_rsp = m_rsp_new;
        e_valid = (kind == 2) && act && (cyc >= ta + 2);
        e_wr = (kind == 1 && act) ? m_be : '0;
        e_core = !(kind == 3 && act);
        e_ready = !act || (kind == 3 && cmd_op == OP_HALT);
        chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
        chk("busy", 64'(busy), 64'(act));
        chk("bram_wr_en", 64'(bram_wr_en), 64'(e_wr));
        chk("bram_addr", 64'(shared_bram_addr), 64'(m_addr));
        chk("bram_din", 64'(bram_din), 64'(m_din));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
        chk("rsp_data", 64'(rsp_data), 64'(m_rsp));
        chk("core_reset", 64'(core_reset), 64'(e_core));
        chk("run_done", 64'(run_done), 64'(done));
        chk("cycle_count", 64'(cycle_count), 64'(m_cnt));
        if (reset) begin
            if (done) rdmem[1] = rdmem[1] + 32'(tl);
            if (!act) kind = 0;
            if (kind == 2 && e_valid && rsp_ready) r_end = cyc + 1;
            if (kind == 3 && cmd_valid && cmd_op == OP_HALT &&
                cyc + 1 - ta < tl) tl = cyc + 1 - ta;
            if (!act && cmd_valid) begin
                mw = cmd_addr[LOGSIZE+1:2];
                ta = cyc + 1;
                case (cmd_op)
                    OP_W: begin
                        kind = 1; m_addr = cmd_addr;
                        m_din = cmd_data; m_be = cmd_be;
                        for (int b = 0; b < NUM_COL; b++) begin
                            if (cmd_be[b] && cmd_addr[ADDR_W-1])
                                rdmem[mw][8*b +: 8] = cmd_data[8*b +: 8];
                            if (cmd_be[b] && !cmd_addr[ADDR_W-1])
                                rimem[mw][8*b +: 8] = cmd_data[8*b +: 8];
                        end
                    end
                    OP_R: begin
                        kind = 2; r_end = BIG; m_addr = cmd_addr;
                        m_rsp_new = cmd_addr[ADDR_W-1] ?
                                    rdmem[mw] : rimem[mw];
                    end
                    OP_RUN: begin
                        kind = 3;
                        tl = (cmd_cycles == 0) ? BIG : longint'(cmd_cycles);
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rsp_ready = (rr_mode == 0) ? 1'($urandom_range(0, 1)) :
                        (rr_mode == 2);
        end
    end

    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] ad,
                        input logic [31:0] d, input logic [NUM_COL-1:0] be,
                        input logic [31:0] n);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = ad;
        cmd_data = d; cmd_be = be; cmd_cycles = n;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] d, output int lat);
        bit ok;
        ok = 0; lat = 0; d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); lat++;
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) chk("rsp_valid_timeout", 64'd0, 64'd1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid && rsp_ready) begin
                d = rsp_data; ok = 1; break;
            end
            @(negedge clk);
        end
        if (!ok) chk("rsp_hs_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] ad, output logic [31:0] d,
                      output int lat);
        send(OP_R, ad, 32'd0, '0, 32'd0);
        get_rsp(d, lat);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] ad, input logic [31:0] d,
                      input logic [NUM_COL-1:0] be);
        send(OP_W, ad, d, be, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int lat, low, pulses, pick;
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0;
        cmd_data = 0; cmd_be = 0; cmd_cycles = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_addr", 64'(shared_bram_addr), 64'd0);
        chk("rst_din", 64'(bram_din), 64'd0);
        chk("rst_wr_en", 64'(bram_wr_en), 64'd0);
        chk("rst_run_done", 64'(run_done), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rel_core_reset", 64'(core_reset), 64'd1);

        wr(9'h004, 32'h0050_0093, 4'hF);
        chk("wr_pulse", 64'(bram_wr_en), 64'hF);
        chk("wr_addr", 64'(shared_bram_addr), 64'h004);
        @(posedge clk); #1;
        chk("wr_drop", 64'(bram_wr_en), 64'd0);
        rd(9'h004, d, lat);
        chk("rd_imem", 64'(d), 64'h0050_0093);
        chk("rd_latency", 64'(lat), 64'd3);

        wr(DBASE | 9'h008, 32'hFFFF_FFFF, 4'hF);
        wr(DBASE | 9'h008, 32'h0000_00AB, 4'h1);
        rd(DBASE | 9'h008, d, lat);
        chk("rd_byte_en", 64'(d), 64'hFFFF_FFAB);

        rr_mode = 1;
        send(OP_R, DBASE | 9'h008, 32'd0, '0, 32'd0);
        repeat (2) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_data", 64'(rsp_data), 64'hFFFF_FFAB);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        rr_mode = 2;
        get_rsp(d, lat);
        chk("bp_after_ready", 64'(cmd_ready), 64'd1);

        send(OP_RUN, '0, 32'd0, '0, 32'd10);
        low = 0; pulses = 0;
        repeat (14) begin
            @(negedge clk);
            if (!core_reset) low++;
            if (run_done) pulses++;
        end
        chk("run_low_cycles", 64'(low), 64'd10);
        chk("run_pulses", 64'(pulses), 64'd1);
        chk("run_count", 64'(cycle_count), 64'd10);
        rd(DBASE | 9'h004, d, lat);
        chk("run_result", 64'(d), 64'd10);

        send(OP_RUN, '0, 32'd0, '0, 32'd0);
        cmd_valid = 1'b1; cmd_op = OP_W; cmd_addr = 9'h010;
        repeat (3) begin
            @(negedge clk);
            chk("run_blocks_wr", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        send(OP_HALT, '0, 32'd0, '0, 32'd0);
        chk("halt_done", 64'(run_done), 64'd1);
        chk("halt_count", 64'(cycle_count), 64'd25);
        chk("halt_core_reset", 64'(core_reset), 64'd1);
        @(posedge clk); #1;
        chk("halt_done_drop", 64'(run_done), 64'd0);
        rd(DBASE | 9'h004, d, lat);
        chk("halt_result", 64'(d), 64'd35);

        send(OP_RUN, '0, 32'd0, '0, 32'd5);
        repeat (3) @(posedge clk);
        send(OP_HALT, '0, 32'd0, '0, 32'd0);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (run_done) pulses++;
        end
        chk("coinc_pulses", 64'(pulses), 64'd1);
        chk("coinc_count", 64'(cycle_count), 64'd5);

        send(OP_HALT, '0, 32'd0, '0, 32'd0);
        chk("idle_halt_busy", 64'(busy), 64'd0);
        chk("idle_halt_done", 64'(run_done), 64'd0);

        send(OP_RUN, '0, 32'd0, '0, 32'd0);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_core_reset", 64'(core_reset), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(cycle_count), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        wr(DBASE | 9'h004, 32'd0, 4'hF);

        rr_mode = 0;
        repeat (150) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 40) begin
                wr(ADDR_W'($urandom), $urandom, NUM_COL'($urandom));
            end else if (pick < 80) begin
                rd(ADDR_W'($urandom), d, lat);
            end else if (pick < 88) begin
                send(OP_RUN, '0, 32'd0, '0, $urandom_range(1, 20));
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (!busy) break;
                end
            end else if (pick < 96) begin
                send(OP_RUN, '0, 32'd0, '0, 32'd0);
                repeat ($urandom_range(0, 30)) @(posedge clk);
                send(OP_HALT, '0, 32'd0, '0, 32'd0);
            end else begin
                send(OP_HALT, '0, 32'd0, '0, 32'd0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rr_mode = 2;
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
